// File: rtl/pic_pkg.sv
// Shared definitions for the nested interrupt controller: register map,
// control bit positions, handshake states and the priority rank helper.
package pic_pkg;

  localparam logic [2:0] ADDR_CTRL  = 3'd0;
  localparam logic [2:0] ADDR_IMR   = 3'd1;
  localparam logic [2:0] ADDR_VBASE = 3'd2;
  localparam logic [2:0] ADDR_ISR   = 3'd3;
  localparam logic [2:0] ADDR_LEVEL = 3'd4;
  localparam logic [2:0] ADDR_IRR   = 3'd5;

  localparam int CTRL_AEOI    = 0;
  localparam int CTRL_ROTATE  = 1;
  localparam int EOI_SPECIFIC = 7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    VECT = 2'd2
  } state_e;

  // Distance of a line from the current highest-priority index; 0 wins.
  function automatic int prioRank(input int idx, input int base, input int n);
    return (idx >= base) ? (idx - base) : (idx + n - base);
  endfunction

endpackage

// File: rtl/pic_prio_resolver.sv
// Rotating-priority find-first: returns the first set request bit scanning
// cyclically upward from base_i.
module pic_prio_resolver #(
  parameter int N_IRQ = 8,
  parameter int IW    = 3
) (
  input  logic [N_IRQ-1:0] req_i,
  input  logic [IW-1:0]    base_i,
  output logic             found_o,
  output logic [IW-1:0]    idx_o
);

  // Scan from lowest priority to highest so the last hit is the winner.
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    for (int k = N_IRQ - 1; k >= 0; k--) begin
      int j;
      j = int'(base_i) + k;
      if (j >= N_IRQ) j = j - N_IRQ;
      if (req_i[j]) begin
        found_o = 1'b1;
        idx_o   = IW'(j);
      end
    end
  end

endmodule

// File: rtl/pic_nested_ctrl.sv
// Programmable interrupt controller: synchronized edge/level requests,
// masking, rotating fully-nested priority and a pulsed vector handshake.
module pic_nested_ctrl
  import pic_pkg::*;
#(
  parameter int N_IRQ = 8,
  parameter int VEC_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_IRQ-1:0] irq_i,
  input  logic             wr_en,
  input  logic             rd_en,
  input  logic [2:0]       addr,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata,
  output logic             int_o,
  input  logic             inta_i,
  output logic             vec_valid,
  output logic [VEC_W-1:0] vec_o
);

  localparam int IW = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

  logic [N_IRQ-1:0] sync1_q, sync2_q, sync3_q;
  logic [N_IRQ-1:0] irr_q, irr_d, isr_q, isr_d, imr_q, level_q;
  logic [1:0]       ctrl_q;
  logic [VEC_W-1:0] vbase_q, vec_q;
  logic [IW-1:0]    pri_q, pri_d, idx_q;
  logic [31:0]      rdata_q, rdNext;
  logic             int_q, vvalid_q, spur_q;
  state_e           state_q;

  logic             candFound, isrFound, qualify, ackReal, eoiValid;
  logic [IW-1:0]    candIdx, isrIdx, eoiIdx;
  logic [N_IRQ-1:0] ackSet, eoiClr, aeoiClr, edgeSet;
  logic             unusedWdata;

  assign unusedWdata = ^wdata;

  pic_prio_resolver #(.N_IRQ(N_IRQ), .IW(IW)) u_cand (
    .req_i(irr_q & ~imr_q), .base_i(pri_q), .found_o(candFound), .idx_o(candIdx)
  );

  pic_prio_resolver #(.N_IRQ(N_IRQ), .IW(IW)) u_isr (
    .req_i(isr_q), .base_i(pri_q), .found_o(isrFound), .idx_o(isrIdx)
  );

  assign qualify = candFound &&
                   (!isrFound || prioRank(int'(candIdx), int'(pri_q), N_IRQ) <
                                 prioRank(int'(isrIdx), int'(pri_q), N_IRQ));
  assign ackReal = (state_q == PEND) && inta_i && qualify;
  assign edgeSet = sync2_q & ~sync3_q & ~level_q;

  function automatic logic [IW-1:0] nextIdx(input logic [IW-1:0] i);
    return (int'(i) == N_IRQ - 1) ? '0 : IW'(int'(i) + 1);
  endfunction

  // EOI decode, ISR/IRR next state and priority rotation; a new edge and a
  // new in-service set each win over a same-cycle clear of the same bit.
  always_comb begin
    eoiValid = 1'b0;
    eoiIdx   = '0;
    eoiClr   = '0;
    ackSet   = '0;
    aeoiClr  = '0;
    if (wr_en && addr == ADDR_ISR && isr_q != '0) begin
      if (wdata[EOI_SPECIFIC]) begin
        if (int'(wdata[4:0]) < N_IRQ) begin
          eoiValid = 1'b1;
          eoiIdx   = IW'(wdata[4:0]);
        end
      end else if (isrFound) begin
        eoiValid = 1'b1;
        eoiIdx   = isrIdx;
      end
    end
    if (eoiValid) eoiClr[eoiIdx] = 1'b1;
    if (ackReal) ackSet[candIdx] = 1'b1;
    if (state_q == VECT && !spur_q && ctrl_q[CTRL_AEOI]) aeoiClr[idx_q] = 1'b1;
    irr_d = (level_q & sync2_q) | (~level_q & ((irr_q & ~ackSet) | edgeSet));
    isr_d = (isr_q & ~eoiClr & ~aeoiClr) | ackSet;
    pri_d = pri_q;
    if (ctrl_q[CTRL_ROTATE] && aeoiClr != '0) pri_d = nextIdx(idx_q);
    if (ctrl_q[CTRL_ROTATE] && eoiValid)      pri_d = nextIdx(eoiIdx);
  end

  always_comb begin
    rdNext = '0;
    case (addr)
      ADDR_CTRL:  rdNext[1:0]       = ctrl_q;
      ADDR_IMR:   rdNext[N_IRQ-1:0] = imr_q;
      ADDR_VBASE: rdNext[VEC_W-1:0] = vbase_q;
      ADDR_ISR:   rdNext[N_IRQ-1:0] = isr_q;
      ADDR_LEVEL: rdNext[N_IRQ-1:0] = level_q;
      ADDR_IRR:   rdNext[N_IRQ-1:0] = irr_q;
      default:    rdNext            = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      sync3_q <= '0;
      irr_q   <= '0;
      isr_q   <= '0;
      imr_q   <= '1;
      level_q <= '0;
      ctrl_q  <= '0;
      vbase_q <= '0;
      pri_q   <= '0;
      rdata_q <= '0;
    end else begin
      sync1_q <= irq_i;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
      irr_q   <= irr_d;
      isr_q   <= isr_d;
      pri_q   <= pri_d;
      if (rd_en) rdata_q <= rdNext;
      if (wr_en) begin
        case (addr)
          ADDR_CTRL:  ctrl_q  <= wdata[1:0];
          ADDR_IMR:   imr_q   <= wdata[N_IRQ-1:0];
          ADDR_VBASE: vbase_q <= wdata[VEC_W-1:0];
          ADDR_LEVEL: level_q <= wdata[N_IRQ-1:0];
          default: ;
        endcase
      end
    end
  end

  // Handshake FSM; an acknowledge with nothing qualifying is spurious.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      int_q    <= 1'b0;
      vvalid_q <= 1'b0;
      vec_q    <= '0;
      idx_q    <= '0;
      spur_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          vvalid_q <= 1'b0;
          if (inta_i) begin
            state_q  <= VECT;
            spur_q   <= 1'b1;
            idx_q    <= IW'(N_IRQ - 1);
            vec_q    <= vbase_q + VEC_W'(N_IRQ - 1);
            vvalid_q <= 1'b1;
            int_q    <= 1'b0;
          end else if (qualify) begin
            state_q <= PEND;
            int_q   <= 1'b1;
          end
        end
        PEND: begin
          vvalid_q <= 1'b0;
          if (inta_i) begin
            state_q  <= VECT;
            vvalid_q <= 1'b1;
            int_q    <= 1'b0;
            spur_q   <= !qualify;
            idx_q    <= qualify ? candIdx : IW'(N_IRQ - 1);
            vec_q    <= vbase_q + (qualify ? VEC_W'(candIdx) : VEC_W'(N_IRQ - 1));
          end else if (!qualify) begin
            state_q <= IDLE;
            int_q   <= 1'b0;
          end
        end
        VECT: begin
          vvalid_q <= 1'b0;
          state_q  <= IDLE;
        end
        default: begin
          state_q  <= IDLE;
          int_q    <= 1'b0;
          vvalid_q <= 1'b0;
        end
      endcase
    end
  end

  assign rdata     = rdata_q;
  assign int_o     = int_q;
  assign vec_valid = vvalid_q;
  assign vec_o     = vec_q;

endmodule

// File: doc/pic_nested_ctrl.md
# pic_nested_ctrl

Parametrised, clocked programmable interrupt controller for N request lines. It follows the 8259A-class block and adds:
- a synchronous register port instead of the raw bus pins;
- per-line edge/level mode;
- rotating priority;
- a single-pulse acknowledge handshake that returns a vector.

It sits between peripheral IRQ lines and the CPU interrupt/acknowledge pins.

## Interface
- N_IRQ, 8, number of request lines (2..32)
- VEC_W, 8, vector width; vector = vec_base + index, modulo 2^VEC_W
- clk  in  1  sole clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- irq_i  in  N_IRQ  asynchronous request lines
- wr_en  in  1  register write strobe, one cycle
- rd_en  in  1  register read strobe, one cycle
- addr  in  3  register address
- wdata  in  32  write data
- rdata  out  32  read data, registered, valid the cycle after rd_en
- int_o  out  1  interrupt request to CPU
- inta_i  in  1  acknowledge, one-cycle pulse
- vec_valid  out  1  one-cycle pulse carrying vec_o
- vec_o  out  VEC_W  vector of the acknowledged line

## Operation
- Registers:
  - 0 CTRL: bit0 AEOI, bit1 ROTATE; reset 0.
  - 1 IMR (1 = masked); reset all-ones.
  - 2 VEC_BASE; reset 0.
  - 3 read ISR / write EOI: bit7 = 1 is specific EOI with index wdata[4:0]; bit7 = 0 is non-specific.
  - 4 LEVEL (per-line 1 = level-sensitive); reset 0.
  - 5 IRR, read-only.
  - Other addresses read 0; writes to them are ignored.
- Request path: irq_i passes through a 2-flop synchronizer.
  - Edge lines set IRR on a synchronized rising edge. IRR is cleared on acknowledge.
  - Level lines: IRR tracks the synchronized level.
- Priority: pri_base (reset 0) is the highest-priority index. Priority descends cyclically from there: pri_base, pri_base+1, …, wrapping at N_IRQ.
- Candidate: the highest-priority bit of IRR & ~IMR.
- int_o is asserted when a candidate exists and it outranks every ISR bit (fully nested).
- FSM:
  - IDLE → PEND when a candidate qualifies.
  - PEND → IDLE if the candidate vanishes before inta_i (mask write, or a level line drops).
  - PEND + inta_i → VECT: latch the index, set ISR[idx], clear IRR[idx] for edge lines, drop int_o.
  - VECT drives vec_valid = 1 and vec_o = VEC_BASE + idx for one cycle.
    - If AEOI: ISR[idx] is cleared in the same cycle.
    - If also ROTATE: pri_base becomes idx+1 (mod N_IRQ).
  - VECT → IDLE.
- inta_i in IDLE is spurious: go to VECT with vec_o = VEC_BASE + N_IRQ-1, no ISR change.
- EOI:
  - Non-specific clears the highest-priority ISR bit.
  - Specific clears ISR[index]. An index ≥ N_IRQ is ignored.
  - If ROTATE is set, pri_base becomes the cleared index + 1 (mod N_IRQ).
  - An EOI with ISR empty does nothing.

## Timing
- Reset values: int_o = 0, vec_valid = 0, vec_o = 0, rdata = 0, FSM = IDLE, IRR = ISR = 0, sync flops = 0.
- Edge latency: irq_i high at edge k → synchronized at k+1 → IRR set at k+2 → int_o high after edge k+3.
- Acknowledge: inta_i sampled at edge a → int_o low and ISR set after a. vec_valid/vec_o are valid in cycle a+1 only. int_o may reassert no earlier than after edge a+2.
- Simultaneous events in one cycle:
  - Register write and inta_i: the acknowledge uses the pre-write IMR, VEC_BASE and pri_base.
  - EOI write and VECT set of ISR: both apply. The set wins if they target the same index.
  - Edge set and acknowledge clear on the same line: the set wins, so the new edge is kept.
- Reset asserted mid-handshake clears everything immediately. A later inta_i is treated as spurious.

## Structure
- Shared package pic_pkg holds:
  - the register address constants;
  - the FSM state enum (IDLE, PEND, VECT);
  - the CTRL bit positions.
- One sub-module, pic_prio_resolver: combinational rotating-priority find-first.
  - Inputs: request vector, pri_base.
  - Outputs: found, index.
  - Instantiated twice, once for the candidate and once for the highest in-service line.

## Test plan
- Edge request on IR3 with IMR = 0 and VEC_BASE = 0x40 → int_o high 3 edges after the request. A single inta_i → vec_o = 0x43. ISR reads 0x08. Non-specific EOI → ISR reads 0.
- IR5 and IR2 raised together, pri_base = 0 → IR2 is vectored first. IR5 is held off until EOI, then IR5 is vectored (nesting).
- ROTATE = 1, AEOI = 1: IR0 and IR1 requests serviced back-to-back → after IR0, pri_base = 1, so the next request sequence gives IR1 before IR0.
- Level line IR6 deasserted in PEND before inta_i → int_o drops. A later inta_i gives spurious vec_o = VEC_BASE + 7 and ISR stays 0.
- Higher-priority IR1 arrives while IR4 is in service → int_o reasserts. Lower-priority IR7 arriving while IR4 is in service stays pending until EOI.
- rst pulsed while vec_valid is pending → all outputs 0 and IMR = 0xFF. N_IRQ = 32: IR31 with VEC_BASE = 0xF0 → vec_o = 0x0F (modulo wrap).
